// File: rtl/large_sub_serial_pkg.sv
// Shared constants and FSM state type for the large-integer add/sub datapath.
package large_sub_serial_pkg;

  localparam int unsigned LIMB_W  = 16;
  localparam int unsigned N_LIMBS = 64;
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/limb_sub16.sv
// Combinational 16-bit limb subtractor d = a - b - bi, with a two-level
// (4x4) generate/propagate borrow lookahead matching the fast adder.
module limb_sub16
  import large_sub_serial_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              bi,
  output logic [LIMB_W-1:0] d,
  output logic              bo
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;
  logic        rc;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  assign g = ~a & b;
  assign p = ~(a ^ b);

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    rc = 1'b0;
    for (int unsigned grp = 0; grp < 4; grp++) begin
      gp[grp] = 1'b1;
      for (int unsigned k = 0; k < 4; k++) begin
        gg[grp] = g[4*grp+k] | (p[4*grp+k] & gg[grp]);
        gp[grp] = gp[grp] & p[4*grp+k];
      end
    end
    gc[0] = bi;
    for (int unsigned grp = 0; grp < 4; grp++) begin
      gc[grp+1] = gg[grp] | (gp[grp] & gc[grp]);
    end
    for (int unsigned grp = 0; grp < 4; grp++) begin
      rc = gc[grp];
      for (int unsigned k = 0; k < 4; k++) begin
        c[4*grp+k] = rc;
        rc = g[4*grp+k] | (p[4*grp+k] & rc);
      end
    end
  end

  assign d  = a ^ b ^ c;
  assign bo = gc[4];

endmodule

// File: rtl/large_sub_serial.sv
// Serial 1024-bit subtractor A - B - BIN, one 16-bit limb per cycle, LS limb first.
// Define LARGE_SUB_CMP_EN to add the eq_out compare output.
module large_sub_serial
  import large_sub_serial_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] a_limb,
  input  logic [LIMB_W-1:0] b_limb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] diff_limb,
  output logic              out_last,
  output logic              done,
  output logic              borrow_out
`ifdef LARGE_SUB_CMP_EN
  ,
  output logic              eq_out
`endif
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_LIMBS - 1);

  state_t            state;
  logic [CNT_W-1:0]  idx;
  logic              borrow;
  logic [LIMB_W-1:0] d;
  logic              bo;
  logic              in_fire;
  logic              out_fire;
`ifdef LARGE_SUB_CMP_EN
  logic              zacc;
`endif

  limb_sub16 u_limb (
    .a  (a_limb),
    .b  (b_limb),
    .bi (borrow),
    .d  (d),
    .bo (bo)
  );

  // Combinational from out_ready so the single output register sustains one limb per cycle.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      borrow     <= 1'b0;
      out_valid  <= 1'b0;
      diff_limb  <= '0;
      out_last   <= 1'b0;
      done       <= 1'b0;
      borrow_out <= 1'b0;
`ifdef LARGE_SUB_CMP_EN
      zacc       <= 1'b0;
      eq_out     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            borrow     <= bin;
            idx        <= '0;
            borrow_out <= 1'b0;
`ifdef LARGE_SUB_CMP_EN
            zacc       <= 1'b1;
            eq_out     <= 1'b0;
`endif
            state      <= RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            diff_limb <= d;
            borrow    <= bo;
            out_valid <= 1'b1;
            out_last  <= (idx == LAST);
            idx       <= idx + 1'b1;
`ifdef LARGE_SUB_CMP_EN
            zacc      <= zacc & (d == '0);
`endif
            if (idx == LAST) begin
              state <= DRAIN;
            end
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_fire && out_last) begin
            out_valid  <= 1'b0;
            done       <= 1'b1;
            borrow_out <= borrow;
`ifdef LARGE_SUB_CMP_EN
            eq_out     <= zacc;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_large_sub_serial.sv
// Scoreboard bench for large_sub_serial: random and directed 1024-bit operands
// checked against a wide-arithmetic reference model.
module tb_large_sub_serial;
  import large_sub_serial_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        bin = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_limb = '0;
  logic [15:0] b_limb = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] diff_limb;
  logic        out_last;
  logic        done;
  logic        borrow_out;
`ifdef LARGE_SUB_CMP_EN
  logic        eq_out;
`endif

  large_sub_serial dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bin        (bin),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_limb     (a_limb),
    .b_limb     (b_limb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff_limb  (diff_limb),
    .out_last   (out_last),
    .done       (done),
    .borrow_out (borrow_out)
`ifdef LARGE_SUB_CMP_EN
    ,
    .eq_out     (eq_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; logic last; } limb_t;
  typedef struct { logic b; logic e; } fin_t;

  limb_t  sb[$];
  fin_t   fq[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     bp = 1'b0;
  bit     aborted = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s got event expected none", name);
  endtask

  // Downstream driver: constant ready, or toggling every cycle for backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp) out_ready = ~out_ready;
      else    out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks stall stability.
  initial begin
    limb_t       e;
    fin_t        f;
    logic [15:0] held;
    logic        held_last;
    bit          stalled;
    stalled = 1'b0;
    held = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) flag("unexpected_limb");
        else begin
          e = sb.pop_front();
          chk("diff_limb", 64'(diff_limb), 64'(e.d));
          chk("out_last", 64'(out_last), 64'(e.last));
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (stalled) begin
          chk("stall_diff_hold", 64'(diff_limb), 64'(held));
          chk("stall_last_hold", 64'(out_last), 64'(held_last));
        end
        held = diff_limb;
        held_last = out_last;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        if (fq.size() == 0) flag("unexpected_done");
        else begin
          f = fq.pop_front();
          chk("borrow_out", 64'(borrow_out), 64'(f.b));
`ifdef LARGE_SUB_CMP_EN
          chk("eq_out", 64'(eq_out), 64'(f.e));
`endif
        end
      end
    end
  end

  task automatic summary_and_finish();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // lat_mode: 0 no latency check, 1 exact unstalled latency, 2 stalled lower bound.
  task automatic run_op(input logic [1023:0] A, input logic [1023:0] B, input logic bi,
                        input int glitch, input int rst_at, input int lat_mode, input bit bubbles);
    logic [1024:0] r;
    limb_t         e;
    fin_t          f;
    longint        t0;
    bit            acc;
    bit            seen;
    r = {1'b0, A} - {1'b0, B} - 1025'(bi);
    for (int i = 0; i < 64; i++) begin
      e.d = r[16*i +: 16];
      e.last = (i == 63);
      sb.push_back(e);
    end
    if (rst_at < 0) begin
      f.b = r[1024];
      f.e = ({1'b0, A} == ({1'b0, B} + 1025'(bi)));
      fq.push_back(f);
    end
    t0 = 0;
    @(posedge clk); #1;
    start = 1'b1;
    bin = bi;
    @(posedge clk); #1;
    start = 1'b0;
    bin = 1'($urandom);
    chk("borrow_out_cleared_at_start", 64'(borrow_out), 64'd0);
    for (int i = 0; i < 64; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff_limb", 64'(diff_limb), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_borrow_out", 64'(borrow_out), 64'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        return;
      end
      if (bubbles && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      a_limb = A[16*i +: 16];
      b_limb = B[16*i +: 16];
      in_valid = 1'b1;
      if (i == glitch) begin
        start = 1'b1;
        bin = ~bi;
      end
      acc = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (!acc) begin
        $display("FAIL accept_timeout got no in_ready expected accept at limb %0d", i);
        errors++;
        checks++;
        summary_and_finish();
      end
      if (i == 0) t0 = cyc;
    end
    in_valid = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 400 && !seen; w++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (lat_mode == 1) chk("latency_cycles", 64'(cyc - t0 + 1), 64'd65);
    if (lat_mode == 2) chk("latency_stalled_ge128", 64'((cyc - t0 + 1) >= 128), 64'd1);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [1023:0] rand1024();
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [1023:0] A;
    logic [1023:0] B;
    #2;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_diff_limb", 64'(diff_limb), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_borrow_out", 64'(borrow_out), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    for (int k = 0; k < 64; k++) A[16*k +: 16] = 16'h0001;
    run_op(A, '0, 1'b0, -1, -1, 1, 1'b0);
    A = '0;
    B = '0;
    B[0] = 1'b1;
    run_op(A, B, 1'b0, -1, -1, 1, 1'b0);
    A = rand1024();
    run_op(A, A, 1'b0, -1, -1, 1, 1'b0);
    run_op(A, A, 1'b1, -1, -1, 1, 1'b0);

    bp = 1'b1;
    A = rand1024();
    B = rand1024();
    run_op(A, B, 1'b1, -1, -1, 2, 1'b0);
    bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_op(rand1024(), rand1024(), 1'b0, -1, 30, 0, 1'b0);
    A = rand1024();
    B = rand1024();
    run_op(A, B, 1'b1, 10, -1, 1, 1'b0);

    for (int n = 0; n < 4; n++) begin
      A = rand1024();
      B = (n == 1) ? A : rand1024();
      run_op(A, B, 1'($urandom), -1, -1, 0, 1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_fq_empty", 64'(fq.size()), 64'd0);
    summary_and_finish();
  end

  initial begin
    #2000000;
    if (!aborted) begin
      aborted = 1'b1;
      $display("FAIL global_timeout got hang expected completion");
      errors++;
      checks++;
      summary_and_finish();
    end
  end

endmodule
